// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the fetch and load/store ports
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              cpu_rst_n,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              cpu_stall,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic              err
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;
   state_t            state, state_n;
   logic              i_done, d_done, i_pend, d_pend, tmo, fin, go_d, go_i, req_n, we_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n, cap;
   logic [CW-1:0]     cnt;
   assign d_pend    = (d_ren | d_wen) & ~d_done;
   assign i_pend    = i_ren & ~i_done;
   assign cpu_stall = d_pend | i_pend;
   assign tmo  = (state != IDLE) & ~ram_ack & (cnt == CW'(ACK_TIMEOUT - 1));
   assign fin  = (state != IDLE) & (ram_ack | tmo);
   assign cap  = tmo ? '0 : ram_rdata;
   // data wins from IDLE since it belongs to the older instruction; chained grants avoid a bubble
   assign go_d = d_pend & ((state == IDLE) | ((state == GNT_I) & fin));
   assign go_i = i_pend & (((state == IDLE) & ~d_pend) | ((state == GNT_D) & fin));
   // next state and the RAM request loaded with each grant
   always_comb begin
      state_n = state;
      req_n   = ram_req;
      we_n    = ram_we;
      addr_n  = ram_addr;
      wdata_n = ram_wdata;
      if (go_d) begin
         state_n = GNT_D;
         req_n   = 1'b1;
         we_n    = d_wen;
         addr_n  = d_addr;
         wdata_n = d_wdata;
      end else if (go_i) begin
         state_n = GNT_I;
         req_n   = 1'b1;
         we_n    = 1'b0;
         addr_n  = i_addr;
      end else if (fin) begin
         state_n = IDLE;
         req_n   = 1'b0;
         we_n    = 1'b0;
      end
   end
   // arbiter state, registered RAM request, ack timeout counter and sticky error
   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state     <= IDLE;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cnt       <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         ram_req   <= req_n;
         ram_we    <= we_n;
         ram_addr  <= addr_n;
         ram_wdata <= wdata_n;
         cnt       <= (go_d | go_i) ? '0 : (state != IDLE && !ram_ack) ? cnt + CW'(1) : cnt;
         err       <= err | tmo;
      end
   end
   // done flags clear when the CPU advances; read data captured on completion
   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_done  <= cpu_stall & (i_done | (fin & (state == GNT_I)));
         d_done  <= cpu_stall & (d_done | (fin & (state == GNT_D)));
         if (fin && state == GNT_I) i_rdata <= cap;
         if (fin && state == GNT_D && d_ren && !d_wen) d_rdata <= cap;
      end
   end
endmodule
